bet_settle: RTL

Bankroll ledger at the consuming end of the bet path. Accepts one committed wager from the bet-entry logic through a valid/ready handshake, holds it until the hand result arrives, then applies the payout to a saturating signed bankroll. Drives the bankroll value and sign to the three-digit-plus-sign display.

---
 rtl/blackjack_pkg.sv | 20 ++
 rtl/payout_calc.sv | 38 +++
 rtl/bet_settle.sv | 109 ++++++++++
 3 files changed

// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - shared widths, limits, outcome codes and state type for the bankroll ledger
package blackjack_pkg;

  localparam int BANK_W   = 11;
  localparam int BET_W    = 8;
  localparam int BANK_MIN = -999;
  localparam int BANK_MAX = 999;

  localparam logic [1:0] LOSE      = 2'd0;
  localparam logic [1:0] PUSH      = 2'd1;
  localparam logic [1:0] WIN       = 2'd2;
  localparam logic [1:0] BLACKJACK = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_OUTCOME,
    S_APPLY
  } state_t;

endpackage

// File: rtl/payout_calc.sv
// rtl/payout_calc.sv - combinational payout: current bankroll, wager and outcome to clamped next bankroll
module payout_calc
  import blackjack_pkg::*;
(
  input  logic signed [BANK_W-1:0] bankroll,
  input  logic        [BET_W-1:0]  bet,
  input  logic        [1:0]        outcome,
  output logic signed [BANK_W-1:0] next_bankroll
);

  // One extra bit so the raw sum never wraps before it is clamped.
  localparam int SUM_W = BANK_W + 1;
  localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(BANK_MIN);
  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(BANK_MAX);

  logic signed [SUM_W-1:0] bet_s;
  logic signed [SUM_W-1:0] delta;
  logic signed [SUM_W-1:0] sum;

  always_comb begin
    bet_s = $signed({{(SUM_W-BET_W){1'b0}}, bet});
    case (outcome)
      LOSE:    delta = -bet_s;
      PUSH:    delta = '0;
      WIN:     delta = bet_s;
      default: delta = bet_s + (bet_s >>> 1);
    endcase
    sum = $signed({bankroll[BANK_W-1], bankroll}) + delta;
    if (sum < SUM_MIN) begin
      next_bankroll = BANK_W'(BANK_MIN);
    end else if (sum > SUM_MAX) begin
      next_bankroll = BANK_W'(BANK_MAX);
    end else begin
      next_bankroll = sum[BANK_W-1:0];
    end
  end

endmodule

// File: rtl/bet_settle.sv
// rtl/bet_settle.sv - bankroll ledger: takes one wager, waits for the hand result, applies the payout
module bet_settle
  import blackjack_pkg::*;
#(
  parameter int START_BANK = 200,
  parameter int BET_MAX    = 99
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bet_valid,
  input  logic        [BET_W-1:0]  bet_amount,
  output logic                     bet_ready,
  output logic                     bet_reject,
  input  logic                     outcome_valid,
  input  logic        [1:0]        outcome,
  output logic signed [BANK_W-1:0] bankroll,
  output logic                     bankroll_neg,
  output logic        [BET_W-1:0]  locked_bet,
  output logic                     settle_done,
  output logic                     game_over
);

  localparam logic        [BET_W-1:0]  BET_MAX_V  = BET_W'(BET_MAX);
  localparam logic signed [BANK_W-1:0] BANK_MIN_V = BANK_W'(BANK_MIN);

  state_t                   state, state_nxt;
  logic        [1:0]        outcome_q;
  logic signed [BANK_W-1:0] bank_nxt;
  logic                     bet_legal;
  logic                     bet_take;
  logic                     bet_drop;
  logic                     outcome_take;

  payout_calc u_payout (
    .bankroll      (bankroll),
    .bet           (locked_bet),
    .outcome       (outcome_q),
    .next_bankroll (bank_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bet_ready    = 1'b0;
    bet_take     = 1'b0;
    bet_drop     = 1'b0;
    outcome_take = 1'b0;
    bet_legal    = (bet_amount != '0) && (bet_amount <= BET_MAX_V);
    case (state)
      S_IDLE: begin
        // Once the player is broke, offers are silently ignored rather than rejected.
        bet_ready = !game_over;
        if (bet_valid && !game_over) begin
          if (bet_legal) begin
            bet_take  = 1'b1;
            state_nxt = S_WAIT_OUTCOME;
          end else begin
            bet_drop = 1'b1;
          end
        end
      end
      S_WAIT_OUTCOME: begin
        if (outcome_valid) begin
          outcome_take = 1'b1;
          state_nxt    = S_APPLY;
        end
      end
      S_APPLY: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bankroll    <= BANK_W'(START_BANK);
      locked_bet  <= '0;
      outcome_q   <= LOSE;
      bet_reject  <= 1'b0;
      settle_done <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      bet_reject  <= bet_drop;
      settle_done <= (state == S_APPLY);
      if (bet_take) begin
        locked_bet <= bet_amount;
      end
      if (outcome_take) begin
        outcome_q <= outcome;
      end
      if (state == S_APPLY) begin
        bankroll   <= bank_nxt;
        locked_bet <= '0;
        if (bank_nxt == BANK_MIN_V) begin
          game_over <= 1'b1;
        end
      end
    end
  end

  assign bankroll_neg = bankroll[BANK_W-1];

endmodule
